pio_avm_master: RTL and testbench
=================================

Name: pio_avm_master

Overview:
- Avalon-MM master that drives the 32-bit bidirectional PIO slave (register map: 0 data, 1 direction, 4 set-bits, 5 clear-bits) on behalf of a local command/response stream.
- Executes WRITE, READ, SET, CLR, read-modify-write and poll-until-match sequences.
- Sits between a control FSM or soft-CPU-less sequencer and the PIO slave port in the SOPC top.
- Slave has no waitrequest and registers readdata every cycle from the current address: read latency is fixed at 1.

Parameters:
- POLL_MAX_TRIES, 1024, maximum reads in one POLL before timeout (>=1).
- POLL_GAP, 0, idle cycles between successive POLL reads (>=0).
- CNT_W, 16, width of the try and gap counters (must hold both POLL_MAX_TRIES and POLL_GAP).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready.
- cmd_op  in  3  0=WRITE 1=READ 2=SET 3=CLR 4=POLL 5=RMW, 6/7 illegal.
- cmd_addr  in  3  PIO register address (WRITE/READ/POLL/RMW).
- cmd_data  in  32  write data / compare value / RMW insert value.
- cmd_mask  in  32  POLL compare mask / RMW field mask.
- rsp_valid  out  1  response present, held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  read data (READ/POLL/RMW pre-write value) or written value (WRITE/SET/CLR).
- rsp_err  out  1  illegal op or POLL timeout.
- avm_address  out  3  to slave address.
- avm_chipselect  out  1  to slave chipselect.
- avm_write_n  out  1  to slave write_n, active-low.
- avm_writedata  out  32  to slave writedata.
- avm_readdata  in  32  from slave readdata.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, on reset_n.
- Reset (also mid-operation):
  - state=IDLE; counters cleared.
  - cmd_ready=0 during the reset cycle, 1 on the first cycle after release.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - A transaction in flight is abandoned; no partial write is issued after reset.
- Output timing: all outputs are registered. cmd_ready=1 only in IDLE. The command is latched on acceptance in cycle C.
- States: IDLE, WR, RD_ADDR, RD_CAP, GAP, RSP.
- WRITE/SET/CLR: C+1 WR (cs=1, write_n=0, one cycle only).
  - address: cmd_addr for WRITE, 4 for SET, 5 for CLR.
  - writedata = cmd_data.
  - C+2 RSP: rsp_data=cmd_data, rsp_err=0.
- READ:
  - C+1 RD_ADDR: cs=1, write_n=1, address=cmd_addr.
  - C+2 RD_CAP: sample avm_readdata into rsp_data.
  - C+3 RSP.
- RMW:
  - READ phase as above.
  - In RD_CAP compute new = (rd & ~cmd_mask) | (cmd_data & cmd_mask).
  - C+3 WR at cmd_addr with new.
  - C+4 RSP with rsp_data = rd (pre-write value).
- POLL:
  - Each try is RD_ADDR then RD_CAP. Try counter increments in RD_CAP.
  - Match when (rd & cmd_mask) == (cmd_data & cmd_mask): go to RSP, rsp_err=0.
  - No match and tries < POLL_MAX_TRIES: go to GAP for POLL_GAP cycles, skipped if 0, then RD_ADDR.
  - No match on try POLL_MAX_TRIES: go to RSP with rsp_err=1, rsp_data = last read.
  - Mask 0 matches on the first try.
- Illegal op (6/7): C+1 RSP, rsp_err=1, rsp_data=0, no bus activity.
- Bus idle: outside RD_ADDR/WR, cs=0 and write_n=1. avm_address and avm_writedata may hold their last value.
- RSP: rsp_valid=1 held with stable data until rsp_valid&rsp_ready in cycle R. rsp_valid=0 and cmd_ready=1 at R+1. Back-to-back commands are therefore separated by one IDLE cycle.
- Simultaneous events: cmd_valid asserted while busy is ignored (no queue). rsp_ready without rsp_valid has no effect.

Test Plan:
- After reset release, WRITE addr=0 data=0xA5A5_0F0F: exactly one cycle cs=1/write_n=0 at C+1 with address 0. rsp_valid at C+2, rsp_data=0xA5A5_0F0F, err=0.
- Slave model returns 0x1234_5678 for addr 1; READ addr=1: address 1 driven at C+1, rsp_data=0x1234_5678 at C+3. Hold rsp_ready=0 for 5 cycles: response stable, cmd_ready=0.
- Slave data=0xFFFF_0000; RMW addr=0 mask=0x0000_FF00 data=0x0000_1200: write of 0xFFFF_1200 at C+3, rsp_data=0xFFFF_0000.
- POLL mask=0x1 data=0x1, slave bit0 set after the 3rd read, POLL_GAP=2: match on try 4, err=0, 2 idle cycles between reads. Same with POLL_MAX_TRIES=4 and bit never set: err=1 after exactly 4 reads.
- SET data=0x80 then CLR data=0x80: writes at addresses 4 and 5. cmd_op=7: err=1 with no cs activity.
- reset_n low for one cycle during POLL RD_CAP: next cycle IDLE, rsp_valid=0, write_n=1, cmd_ready=1 after release, and the next READ completes normally.

Source files
------------

// File: rtl/pio_avm_master.sv
// Avalon-MM master for a 32-bit bidirectional PIO slave: turns local commands into
// single-beat writes, fixed-latency reads, read-modify-writes and bounded polls.
module pio_avm_master #(
    parameter int POLL_MAX_TRIES = 1024,
    parameter int POLL_GAP       = 0,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_CAP  = 3'd3,
        ST_GAP     = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_SET   = 3'd2;
    localparam logic [2:0] OP_CLR   = 3'd3;
    localparam logic [2:0] OP_POLL  = 3'd4;
    localparam logic [2:0] OP_RMW   = 3'd5;

    localparam logic [2:0] ADDR_SET = 3'd4;
    localparam logic [2:0] ADDR_CLR = 3'd5;

    // try_r holds completed tries, so the last allowed try sees MAX-1 here
    localparam logic [CNT_W-1:0] TRIES_LAST = CNT_W'(POLL_MAX_TRIES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(POLL_GAP - 1);

    function automatic logic [31:0] rmw_merge(input logic [31:0] rd, input logic [31:0] ins,
                                              input logic [31:0] mask);
        return (rd & ~mask) | (ins & mask);
    endfunction

    function automatic logic masked_eq(input logic [31:0] rd, input logic [31:0] cmp,
                                       input logic [31:0] mask);
        return ((rd ^ cmp) & mask) == 32'd0;
    endfunction

    state_t            state_r, state_s;
    logic [2:0]        op_r, op_s;
    logic [2:0]        addr_r, addr_s;
    logic [31:0]       data_r, data_s;
    logic [31:0]       mask_r, mask_s;
    logic [CNT_W-1:0]  try_r, try_s;
    logic [CNT_W-1:0]  gap_r, gap_s;

    logic              cmd_ready_s, rsp_valid_s, rsp_err_s;
    logic [31:0]       rsp_data_s, writedata_s;
    logic [2:0]        address_s;
    logic              cs_s, write_n_s;
    logic              accept_s, poll_hit_s;

    assign accept_s   = cmd_valid & cmd_ready;
    assign poll_hit_s = masked_eq(avm_readdata, data_r, mask_r);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_WRITE, OP_SET, OP_CLR: state_s = ST_WR;
                        OP_READ, OP_POLL, OP_RMW: state_s = ST_RD_ADDR;
                        default:                  state_s = ST_RSP;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR:      state_s = ST_RSP;
            ST_RD_ADDR: state_s = ST_RD_CAP;
            ST_RD_CAP: begin
                case (op_r)
                    OP_RMW: state_s = ST_WR;
                    OP_POLL: begin
                        if (poll_hit_s || (try_r == TRIES_LAST)) begin
                            state_s = ST_RSP;
                        end else if (POLL_GAP == 0) begin
                            state_s = ST_RD_ADDR;
                        end else begin
                            state_s = ST_GAP;
                        end
                    end
                    default: state_s = ST_RSP;
                endcase
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_s = ST_RD_ADDR;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of outputs and command latch, derived from the upcoming state
    always_comb begin
        cmd_ready_s = (state_s == ST_IDLE);
        rsp_valid_s = (state_s == ST_RSP);
        cs_s        = (state_s == ST_WR) || (state_s == ST_RD_ADDR);
        write_n_s   = (state_s != ST_WR);
        address_s   = avm_address;
        writedata_s = avm_writedata;
        rsp_data_s  = rsp_data;
        rsp_err_s   = rsp_err;
        op_s        = op_r;
        addr_s      = addr_r;
        data_s      = data_r;
        mask_s      = mask_r;
        try_s       = try_r;
        gap_s       = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    op_s   = cmd_op;
                    addr_s = cmd_addr;
                    data_s = cmd_data;
                    mask_s = cmd_mask;
                    try_s  = '0;
                    gap_s  = '0;
                    case (cmd_op)
                        OP_WRITE, OP_SET, OP_CLR: begin
                            if (cmd_op == OP_SET) begin
                                address_s = ADDR_SET;
                            end else if (cmd_op == OP_CLR) begin
                                address_s = ADDR_CLR;
                            end else begin
                                address_s = cmd_addr;
                            end
                            writedata_s = cmd_data;
                            rsp_data_s  = cmd_data;
                            rsp_err_s   = 1'b0;
                        end
                        OP_READ, OP_POLL, OP_RMW: begin
                            address_s  = cmd_addr;
                            rsp_data_s = 32'd0;
                            rsp_err_s  = 1'b0;
                        end
                        default: begin
                            rsp_data_s = 32'd0;
                            rsp_err_s  = 1'b1;
                        end
                    endcase
                end else begin
                    rsp_err_s = rsp_err;
                end
            end
            ST_RD_CAP: begin
                rsp_data_s = avm_readdata;
                try_s      = try_r + CNT_W'(1);
                gap_s      = '0;
                if (op_r == OP_RMW) begin
                    writedata_s = rmw_merge(avm_readdata, data_r, mask_r);
                end else begin
                    writedata_s = avm_writedata;
                end
                rsp_err_s = (op_r == OP_POLL) && !poll_hit_s && (try_r == TRIES_LAST);
            end
            ST_GAP: begin
                gap_s = gap_r + CNT_W'(1);
            end
            default: begin
                gap_s = gap_r;
            end
        endcase
    end

    // Registered outputs and latched command; reset abandons any transfer in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= 32'd0;
            rsp_err        <= 1'b0;
            avm_address    <= 3'd0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= 32'd0;
            op_r           <= 3'd0;
            addr_r         <= 3'd0;
            data_r         <= 32'd0;
            mask_r         <= 32'd0;
            try_r          <= '0;
            gap_r          <= '0;
        end else begin
            cmd_ready      <= cmd_ready_s;
            rsp_valid      <= rsp_valid_s;
            rsp_data       <= rsp_data_s;
            rsp_err        <= rsp_err_s;
            avm_address    <= address_s;
            avm_chipselect <= cs_s;
            avm_write_n    <= write_n_s;
            avm_writedata  <= writedata_s;
            op_r           <= op_s;
            addr_r         <= addr_s;
            data_r         <= data_s;
            mask_r         <= mask_s;
            try_r          <= try_s;
            gap_r          <= gap_s;
        end
    end

endmodule

// File: tb/tb_pio_avm_master.sv
// Self-checking bench for pio_avm_master: PIO slave model, bus monitor and a
// transaction-level reference model predicting responses, latencies and bus beats.
module tb_pio_avm_master;

    localparam int MAX_TRIES = 4;
    localparam int GAP       = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op, cmd_addr;
    logic [31:0] cmd_data, cmd_mask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [2:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [31:0] avm_writedata, avm_readdata;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    pio_avm_master #(.POLL_MAX_TRIES(MAX_TRIES), .POLL_GAP(GAP), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: set/clear registers act on data; address 2 is a poll source whose
    // bit 0 rises after three reads once poll_en is set
    logic [31:0] slv [8];
    int          rd2_cnt;
    bit          poll_en = 1'b0;
    int          poll_base = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) slv[i] <= 32'd0;
            rd2_cnt      <= 0;
            avm_readdata <= 32'd0;
        end else begin
            if (avm_chipselect && !avm_write_n) begin
                if (avm_address == 3'd4)      slv[0] <= slv[0] | avm_writedata;
                else if (avm_address == 3'd5) slv[0] <= slv[0] & ~avm_writedata;
                else                          slv[avm_address] <= avm_writedata;
            end
            if (avm_chipselect && avm_write_n && avm_address == 3'd2) rd2_cnt <= rd2_cnt + 1;
            if (avm_address == 3'd2)
                avm_readdata <= (poll_en && (rd2_cnt - poll_base) >= 3) ? 32'd1 : 32'd0;
            else
                avm_readdata <= slv[avm_address];
        end
    end

    typedef struct {
        int          cyc;
        logic        wr;
        logic [2:0]  a;
        logic [31:0] d;
    } bus_t;

    bus_t bus_q[$];

    always @(negedge clk) begin
        if (avm_chipselect) begin
            bus_t e;
            e.cyc = cyc; e.wr = !avm_write_n; e.a = avm_address; e.d = avm_writedata;
            bus_q.push_back(e);
        end
    end

    // Reference model state: what the PIO registers should contain
    logic [31:0] mdl [8];

    function automatic bus_t mk(input int c, input logic w, input logic [2:0] a, input logic [31:0] d);
        bus_t e;
        e.cyc = c; e.wr = w; e.a = a; e.d = d;
        return e;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [2:0] a, input int k);
        if (a == 3'd2) return (poll_en && k > 3) ? 32'd1 : 32'd0;
        return mdl[a];
    endfunction

    task automatic mdl_write(input logic [2:0] a, input logic [31:0] d);
        if (a == 3'd4)      mdl[0] = mdl[0] | d;
        else if (a == 3'd5) mdl[0] = mdl[0] & ~d;
        else                mdl[a] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [2:0] a, input logic [31:0] d,
                           input logic [31:0] m, input int hold, input bit noise);
        bus_t        exp_q[$];
        logic [31:0] exp_data, rd, nv;
        logic        exp_err, hit;
        logic [2:0]  wa;
        int          lat, acc, rc, b0, k, n;

        case (op)
            3'd0, 3'd2, 3'd3: begin
                wa = (op == 3'd0) ? a : ((op == 3'd2) ? 3'd4 : 3'd5);
                exp_q.push_back(mk(1, 1'b1, wa, d));
                lat = 2; exp_data = d; exp_err = 1'b0;
                mdl_write(wa, d);
            end
            3'd1: begin
                exp_q.push_back(mk(1, 1'b0, a, 32'd0));
                lat = 3; exp_data = mdl_read(a, 1); exp_err = 1'b0;
            end
            3'd5: begin
                rd = mdl_read(a, 1);
                nv = (rd & ~m) | (d & m);
                exp_q.push_back(mk(1, 1'b0, a, 32'd0));
                exp_q.push_back(mk(3, 1'b1, a, nv));
                lat = 4; exp_data = rd; exp_err = 1'b0;
                mdl_write(a, nv);
            end
            3'd4: begin
                hit = 1'b0; k = 0; rd = 32'd0;
                while (!hit && k < MAX_TRIES) begin
                    k++;
                    exp_q.push_back(mk(1 + (k - 1) * (2 + GAP), 1'b0, a, 32'd0));
                    rd  = mdl_read(a, k);
                    hit = ((rd ^ d) & m) == 32'd0;
                end
                lat = 3 + (k - 1) * (2 + GAP); exp_data = rd; exp_err = !hit;
            end
            default: begin
                lat = 1; exp_data = 32'd0; exp_err = 1'b1;
            end
        endcase

        b0 = bus_q.size();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
        rsp_ready = 1'b0;
        acc = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            if (cmd_ready) acc = cyc;
            else @(negedge clk);
        end
        if (acc < 0) begin
            chk("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rc = -1;
        for (int i = 0; i < 64 && rc < 0; i++) begin
            if (rsp_valid) begin
                rc = cyc;
            end else begin
                if (noise) begin
                    cmd_valid = 1'($urandom_range(0, 1));
                    cmd_op    = 3'($urandom_range(0, 7));
                    cmd_data  = $urandom;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        if (rc < 0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", 32'(rc - acc), 32'(lat));
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", rsp_data, exp_data);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);

        n = bus_q.size() - b0;
        chk("bus_beats", 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk("bus_cycle", 32'(bus_q[b0 + i].cyc - acc), 32'(exp_q[i].cyc));
            chk("bus_wr", 32'(bus_q[b0 + i].wr), 32'(exp_q[i].wr));
            chk("bus_addr", 32'(bus_q[b0 + i].a), 32'(exp_q[i].a));
            if (exp_q[i].wr) chk("bus_wdata", bus_q[b0 + i].d, exp_q[i].d);
        end
        for (int i = 0; i < 8; i++) chk("slave_reg", slv[i], mdl[i]);
    endtask

    initial begin
        logic [2:0]  op, a;
        logic [31:0] m;
        int          acc;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 3'd0;
        cmd_data = 32'd0; cmd_mask = 32'd0; rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_write_n", 32'(avm_write_n), 32'd1);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        run_cmd(3'd0, 3'd0, 32'hA5A5_0F0F, 32'd0, 0, 1'b0);
        run_cmd(3'd0, 3'd1, 32'h1234_5678, 32'd0, 0, 1'b0);
        run_cmd(3'd1, 3'd1, 32'd0, 32'd0, 5, 1'b0);
        run_cmd(3'd0, 3'd0, 32'hFFFF_0000, 32'd0, 0, 1'b0);
        run_cmd(3'd5, 3'd0, 32'h0000_1200, 32'h0000_FF00, 0, 1'b0);
        chk("rmw_result", slv[0], 32'hFFFF_1200);

        poll_en = 1'b1; poll_base = rd2_cnt;
        run_cmd(3'd4, 3'd2, 32'd1, 32'd1, 0, 1'b0);
        poll_en = 1'b0; poll_base = rd2_cnt;
        run_cmd(3'd4, 3'd2, 32'd1, 32'd1, 0, 1'b0);
        run_cmd(3'd4, 3'd0, 32'h5555_AAAA, 32'd0, 0, 1'b0);

        run_cmd(3'd2, 3'd0, 32'h0000_0080, 32'd0, 0, 1'b0);
        run_cmd(3'd3, 3'd0, 32'h0000_0080, 32'd0, 0, 1'b0);
        run_cmd(3'd7, 3'd1, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
        run_cmd(3'd6, 3'd0, 32'h1111_2222, 32'd0, 0, 1'b0);

        // Reset while a poll sits in its capture cycle
        poll_en = 1'b0; poll_base = rd2_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_addr = 3'd2; cmd_data = 32'd1; cmd_mask = 32'd1;
        chk("mid_pre_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_rd_cs", 32'(avm_chipselect), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_write_n", 32'(avm_write_n), 32'd1);
        chk("mid_cs", 32'(avm_chipselect), 32'd0);
        chk("mid_cmd_ready_rst", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("mid_cmd_ready_rel", 32'(cmd_ready), 32'd1);
        chk("mid_cs_rel", 32'(avm_chipselect), 32'd0);
        run_cmd(3'd1, 3'd1, 32'd0, 32'd0, 0, 1'b0);
        run_cmd(3'd0, 3'd1, 32'hCAFE_F00D, 32'd0, 0, 1'b0);
        run_cmd(3'd1, 3'd1, 32'd0, 32'd0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            op = 3'($urandom_range(0, 7));
            a  = 3'($urandom_range(0, 7));
            if (a == 3'd2) a = 3'd3;
            m = (t % 7 == 0) ? 32'd0 : ($urandom & $urandom & $urandom);
            run_cmd(op, a, $urandom, m, $urandom_range(0, 2), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
